// File: rtl/segment_arbiter.sv
// Round-robin bus arbiter with transaction hold, decode-error abort and watchdog abort.
// Produces a registered one-hot grant plus its binary index for the shared segment.
module segment_arbiter #(
  parameter int masters = 2,
  parameter int timeout = 1024,
  parameter int id_bits = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [masters-1:0] REQUESTS,
  input  logic               DONE,
  input  logic               SELECT_ERROR,
  output logic [masters-1:0] BUS_GRANTS,
  output logic [id_bits-1:0] GRANT_ID,
  output logic               BUSY,
  output logic               DECODE_ERROR,
  output logic               TIMEOUT
);

  localparam int WDOG_W = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(timeout);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((timeout > 0) ? timeout - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ABORT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [masters-1:0]  grant_q, grant_d;
  logic [id_bits-1:0]  id_q, id_d;
  logic                busy_q, busy_d;
  logic                derr_q, derr_d;
  logic                tout_q, tout_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [id_bits-1:0]  last_ptr_q, last_ptr_d;

  logic                hi_found, lo_found;
  logic [id_bits-1:0]  hi_idx, lo_idx, win_idx;
  logic [masters-1:0]  win_onehot;
  logic                any_req;

  // Round-robin pick: lowest requester above last_ptr, otherwise lowest overall.
  // Scanning downward leaves the lowest matching index in each candidate.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = masters - 1; j >= 0; j--) begin
      if (REQUESTS[j]) begin
        if (j > int'(last_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = id_bits'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = id_bits'(j);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    any_req = hi_found | lo_found;
  end

  genvar gi;
  generate
    for (gi = 0; gi < masters; gi++) begin : g_onehot
      assign win_onehot[gi] = (int'(win_idx) == gi);
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    busy_d     = busy_q;
    derr_d     = 1'b0;
    tout_d     = 1'b0;
    wdog_d     = wdog_q;
    last_ptr_d = last_ptr_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
        if (any_req) begin
          grant_d = win_onehot;
          id_d    = win_idx;
          busy_d  = 1'b1;
          wdog_d  = '0;
          state_d = GRANTED;
        end
      end

      GRANTED: begin
        if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (DONE) begin
          grant_d    = '0;
          id_d       = '0;
          busy_d     = 1'b0;
          last_ptr_d = id_q;
          state_d    = IDLE;
        end else if (SELECT_ERROR) begin
          derr_d  = 1'b1;
          state_d = ABORT;
        end else if ((timeout != 0) && (wdog_q == WDOG_LAST)) begin
          tout_d  = 1'b1;
          state_d = ABORT;
        end
      end

      ABORT: begin
        grant_d    = '0;
        id_d       = '0;
        busy_d     = 1'b0;
        last_ptr_d = id_q;
        state_d    = IDLE;
      end

      default: begin
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      id_q       <= '0;
      busy_q     <= 1'b0;
      derr_q     <= 1'b0;
      tout_q     <= 1'b0;
      wdog_q     <= '0;
      last_ptr_q <= id_bits'(masters - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      id_q       <= id_d;
      busy_q     <= busy_d;
      derr_q     <= derr_d;
      tout_q     <= tout_d;
      wdog_q     <= wdog_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign BUS_GRANTS   = grant_q;
  assign GRANT_ID     = id_q;
  assign BUSY         = busy_q;
  assign DECODE_ERROR = derr_q;
  assign TIMEOUT      = tout_q;

endmodule

// File: tb/tb_segment_arbiter.sv
// Directed bench for segment_arbiter (3 masters, 8-cycle watchdog).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_segment_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] REQUESTS;
  logic       DONE;
  logic       SELECT_ERROR;
  logic [2:0] BUS_GRANTS;
  logic [1:0] GRANT_ID;
  logic       BUSY;
  logic       DECODE_ERROR;
  logic       TIMEOUT;

  int total = 0;
  int bad   = 0;

  segment_arbiter #(
    .masters(3),
    .timeout(8),
    .id_bits(2)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQUESTS     (REQUESTS),
    .DONE         (DONE),
    .SELECT_ERROR (SELECT_ERROR),
    .BUS_GRANTS   (BUS_GRANTS),
    .GRANT_ID     (GRANT_ID),
    .BUSY         (BUSY),
    .DECODE_ERROR (DECODE_ERROR),
    .TIMEOUT      (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] g, input logic [1:0] id,
                              input logic b, input logic de, input logic to);
    check({tag, ".grants"}, 32'(BUS_GRANTS), 32'(g));
    check({tag, ".id"},     32'(GRANT_ID),   32'(id));
    check({tag, ".busy"},   32'(BUSY),       32'(b));
    check({tag, ".derr"},   32'(DECODE_ERROR), 32'(de));
    check({tag, ".tout"},   32'(TIMEOUT),    32'(to));
  endtask

  initial begin
    RESET        = 1'b1;
    REQUESTS     = 3'b000;
    DONE         = 1'b0;
    SELECT_ERROR = 1'b0;
    #3;
    expect_state("reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    expect_state("post_reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Round robin with all three requesting: 0, 1, 2, 0 with one idle cycle between grants.
    REQUESTS = 3'b111;
    tick();
    expect_state("rr0", 3'b001, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("rr0.hold", 32'(BUS_GRANTS), 32'h1);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    expect_state("rr0.rel", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_state("rr1", 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("rr1.rel", 32'(BUS_GRANTS), 32'h0);
    tick();
    expect_state("rr2", 3'b100, 2'd2, 1'b1, 1'b0, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("rr2.rel", 32'(BUSY), 32'h0);
    tick();
    expect_state("rr3", 3'b001, 2'd0, 1'b1, 1'b0, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    REQUESTS = 3'b000;
    tick();
    check("idle.grants", 32'(BUS_GRANTS), 32'h0);

    // DONE and SELECT_ERROR in IDLE have no effect.
    DONE = 1'b1;
    SELECT_ERROR = 1'b1;
    tick();
    DONE = 1'b0;
    SELECT_ERROR = 1'b0;
    expect_state("idle_ignore", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Lone requester master 1 is re-granted after every one-cycle gap.
    REQUESTS = 3'b010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("solo%0d.g", k), 32'(BUS_GRANTS), 32'h2);
      tick();
      check($sformatf("solo%0d.h1", k), 32'(BUS_GRANTS), 32'h2);
      tick();
      check($sformatf("solo%0d.h2", k), 32'(GRANT_ID), 32'h1);
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      check($sformatf("solo%0d.rel", k), 32'(BUS_GRANTS), 32'h0);
    end
    REQUESTS = 3'b000;
    tick();

    // Decode error on master 2; next search starts at master 0.
    REQUESTS = 3'b100;
    tick();
    expect_state("sel.g", 3'b100, 2'd2, 1'b1, 1'b0, 1'b0);
    SELECT_ERROR = 1'b1;
    tick();
    SELECT_ERROR = 1'b0;
    REQUESTS = 3'b111;
    expect_state("sel.abort", 3'b100, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    expect_state("sel.clear", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_state("sel.next", 3'b001, 2'd0, 1'b1, 1'b0, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    REQUESTS = 3'b000;
    tick();

    // Watchdog: TIMEOUT on the 8th edge after the granting edge.
    REQUESTS = 3'b010;
    tick();
    check("wd.g", 32'(BUS_GRANTS), 32'h2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("wd.quiet%0d", k), 32'({TIMEOUT, BUS_GRANTS}), 32'h2);
    end
    tick();
    expect_state("wd.fire", 3'b010, 2'd1, 1'b1, 1'b0, 1'b1);
    tick();
    expect_state("wd.clear", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("wd.regrant", 32'(BUS_GRANTS), 32'h2);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    REQUESTS = 3'b000;

    // DONE wins over SELECT_ERROR; dropped request does not release the grant.
    REQUESTS = 3'b100;
    tick();
    check("drop.g", 32'(BUS_GRANTS), 32'h4);
    REQUESTS = 3'b000;
    tick();
    check("drop.h1", 32'(BUS_GRANTS), 32'h4);
    tick();
    check("drop.h2", 32'(BUSY), 32'h1);
    DONE = 1'b1;
    SELECT_ERROR = 1'b1;
    tick();
    DONE = 1'b0;
    SELECT_ERROR = 1'b0;
    expect_state("both.rel", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("both.after", 32'({DECODE_ERROR, BUS_GRANTS}), 32'h0);

    // Asynchronous reset mid-grant, then fresh arbitration from master 0.
    REQUESTS = 3'b001;
    tick();
    check("ar.g", 32'(BUS_GRANTS), 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    check("ar.grants", 32'(BUS_GRANTS), 32'h0);
    check("ar.busy", 32'(BUSY), 32'h0);
    tick();
    RESET = 1'b0;
    REQUESTS = 3'b110;
    tick();
    expect_state("ar.first", 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
